// File: rtl/sram_arbiter_if.sv
// SRAM-like request/response bus shared by the fetch port, the data port and
// the downstream memory port of sram_arbiter.
//   master : drives req/wr/size/wstrb/addr/wdata, receives addr_ok/data_ok/rdata
//   slave  : the opposite side
interface sram_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-to-one arbiter sharing one SRAM-like memory port between instruction
// fetch and data access. Data has priority; a grant is held until its address
// handshake completes. An in-order id FIFO routes each response back to the
// requester that issued it.
//   clk, reset : clock, asynchronous active-high reset
//   inst       : fetch requester (only req/addr used; reads only)
//   data       : data requester (loads and stores)
//   mem        : shared downstream port
//   err        : sticky flag, set by a response with nothing outstanding
module sram_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  sram_arbiter_if.slave  inst,
  sram_arbiter_if.slave  data,
  sram_arbiter_if.master mem,
  output logic           err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic        ID_INST = 1'b0;
  localparam logic        ID_DATA = 1'b1;

  logic             lock;
  logic             lock_id;
  logic             fifo [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic grant_valid;
  logic grant_id;
  logic push;
  logic pop;
  logic head;

  // Fetch-side write fields are meaningless for instruction reads.
  wire unused_inst = &{1'b0, inst.wr, inst.size, inst.wstrb, inst.wdata};

  // Grant selection: a held lock wins; otherwise data over inst when not full.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = ID_INST;
    if (!reset) begin
      if (lock) begin
        grant_valid = 1'b1;
        grant_id    = lock_id;
      end else if (count < CNT_W'(DEPTH)) begin
        if (data.req) begin
          grant_valid = 1'b1;
          grant_id    = ID_DATA;
        end else if (inst.req) begin
          grant_valid = 1'b1;
          grant_id    = ID_INST;
        end
      end
    end
  end

  // Downstream mux; fetches are always word reads.
  always_comb begin
    mem.req   = grant_valid;
    mem.wr    = 1'b0;
    mem.size  = 2'd0;
    mem.wstrb = 4'd0;
    mem.addr  = 32'd0;
    mem.wdata = 32'd0;
    if (grant_valid) begin
      if (grant_id == ID_DATA) begin
        mem.wr    = data.wr;
        mem.size  = data.size;
        mem.wstrb = data.wstrb;
        mem.addr  = data.addr;
        mem.wdata = data.wdata;
      end else begin
        mem.size  = 2'd2;
        mem.addr  = inst.addr;
      end
    end
  end

  assign push = grant_valid && mem.addr_ok;
  assign pop  = !reset && mem.data_ok && (count != '0);
  assign head = fifo[rd_ptr];

  assign inst.addr_ok = grant_valid && (grant_id == ID_INST) && mem.addr_ok;
  assign data.addr_ok = grant_valid && (grant_id == ID_DATA) && mem.addr_ok;
  assign inst.data_ok = pop && (head == ID_INST);
  assign data.data_ok = pop && (head == ID_DATA);
  assign inst.rdata   = mem.rdata;
  assign data.rdata   = mem.rdata;

  // Lock, id FIFO, outstanding count and error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock    <= 1'b0;
      lock_id <= ID_INST;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err     <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) fifo[i] <= ID_INST;
    end else begin
      lock    <= grant_valid && !mem.addr_ok;
      lock_id <= grant_id;
      if (push) begin
        fifo[wr_ptr] <= grant_id;
        wr_ptr       <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (mem.data_ok && (count == '0)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: priority, lock hold, response routing,
// full blocking, stray-response error and asynchronous reset.
module tb_sram_arbiter;

  logic clk;
  logic reset;
  logic err;
  int   total;
  int   bad;

  sram_arbiter_if inst_bus ();
  sram_arbiter_if data_bus ();
  sram_arbiter_if mem_bus ();

  sram_arbiter #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .inst  (inst_bus),
    .data  (data_bus),
    .mem   (mem_bus),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    inst_bus.req     = 1'b0;
    inst_bus.addr    = 32'd0;
    data_bus.req     = 1'b0;
    data_bus.wr      = 1'b0;
    data_bus.size    = 2'd2;
    data_bus.wstrb   = 4'd0;
    data_bus.addr    = 32'd0;
    data_bus.wdata   = 32'd0;
    mem_bus.addr_ok  = 1'b0;
    mem_bus.data_ok  = 1'b0;
    mem_bus.rdata    = 32'd0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle();
    // Fetch-side write fields carry junk that must never reach the memory port.
    inst_bus.wr    = 1'b1;
    inst_bus.size  = 2'd1;
    inst_bus.wstrb = 4'hf;
    inst_bus.wdata = 32'hDEADBEEF;
    inst_bus.req   = 1'b1;
    mem_bus.addr_ok = 1'b1;
    settle();
    chk("rst_mem_req", 32'(mem_bus.req), 32'd0);
    chk("rst_inst_aok", 32'(inst_bus.addr_ok), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    tick();
    tick();
    idle();
    reset = 1'b0;
    settle();
    chk("idle_mem_req", 32'(mem_bus.req), 32'd0);
    chk("idle_mem_addr", mem_bus.addr, 32'd0);

    // Priority: both request together, data wins, inst follows.
    inst_bus.req = 1'b1; inst_bus.addr = 32'h1000;
    data_bus.req = 1'b1; data_bus.addr = 32'h2000;
    mem_bus.addr_ok = 1'b1;
    settle();
    chk("pri_mem_addr", mem_bus.addr, 32'h2000);
    chk("pri_data_aok", 32'(data_bus.addr_ok), 32'd1);
    chk("pri_inst_aok", 32'(inst_bus.addr_ok), 32'd0);
    tick();
    data_bus.req = 1'b0;
    settle();
    chk("pri2_mem_addr", mem_bus.addr, 32'h1000);
    chk("pri2_inst_aok", 32'(inst_bus.addr_ok), 32'd1);
    chk("pri2_data_aok", 32'(data_bus.addr_ok), 32'd0);
    tick();
    inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b0;
    mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h11;
    settle();
    chk("pri_rsp0_data", 32'(data_bus.data_ok), 32'd1);
    chk("pri_rsp0_inst", 32'(inst_bus.data_ok), 32'd0);
    chk("pri_rsp0_rdata", data_bus.rdata, 32'h11);
    tick();
    mem_bus.rdata = 32'h22;
    settle();
    chk("pri_rsp1_inst", 32'(inst_bus.data_ok), 32'd1);
    chk("pri_rsp1_data", 32'(data_bus.data_ok), 32'd0);
    chk("pri_rsp1_rdata", inst_bus.rdata, 32'h22);
    tick();
    mem_bus.data_ok = 1'b0;

    // Lock: inst stalled 3 cycles; data arriving later must wait.
    inst_bus.req = 1'b1; inst_bus.addr = 32'h3000;
    settle();
    chk("lock_c1_addr", mem_bus.addr, 32'h3000);
    chk("lock_c1_aok", 32'(inst_bus.addr_ok), 32'd0);
    tick();
    data_bus.req = 1'b1; data_bus.addr = 32'h4000;
    settle();
    chk("lock_c2_addr", mem_bus.addr, 32'h3000);
    tick();
    settle();
    chk("lock_c3_addr", mem_bus.addr, 32'h3000);
    chk("lock_c3_daok", 32'(data_bus.addr_ok), 32'd0);
    tick();
    mem_bus.addr_ok = 1'b1;
    settle();
    chk("lock_c4_addr", mem_bus.addr, 32'h3000);
    chk("lock_c4_iaok", 32'(inst_bus.addr_ok), 32'd1);
    chk("lock_c4_daok", 32'(data_bus.addr_ok), 32'd0);
    tick();
    inst_bus.req = 1'b0;
    settle();
    chk("lock_c5_addr", mem_bus.addr, 32'h4000);
    chk("lock_c5_daok", 32'(data_bus.addr_ok), 32'd1);
    tick();
    data_bus.req = 1'b0; mem_bus.addr_ok = 1'b0;
    mem_bus.data_ok = 1'b1;
    settle();
    chk("lock_rsp0_inst", 32'(inst_bus.data_ok), 32'd1);
    tick();
    settle();
    chk("lock_rsp1_data", 32'(data_bus.data_ok), 32'd1);
    tick();
    mem_bus.data_ok = 1'b0;

    // In-order routing: inst, store, inst.
    mem_bus.addr_ok = 1'b1;
    inst_bus.req = 1'b1; inst_bus.addr = 32'h1000;
    settle();
    chk("ord_i0_wr", 32'(mem_bus.wr), 32'd0);
    chk("ord_i0_size", 32'(mem_bus.size), 32'd2);
    chk("ord_i0_wstrb", 32'(mem_bus.wstrb), 32'd0);
    chk("ord_i0_wdata", mem_bus.wdata, 32'd0);
    tick();
    inst_bus.req = 1'b0;
    data_bus.req = 1'b1; data_bus.wr = 1'b1; data_bus.addr = 32'h2000;
    data_bus.wstrb = 4'hf; data_bus.wdata = 32'h55;
    settle();
    chk("ord_st_wr", 32'(mem_bus.wr), 32'd1);
    chk("ord_st_wstrb", 32'(mem_bus.wstrb), 32'hf);
    chk("ord_st_wdata", mem_bus.wdata, 32'h55);
    chk("ord_st_addr", mem_bus.addr, 32'h2000);
    tick();
    data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.wstrb = 4'd0;
    inst_bus.req = 1'b1; inst_bus.addr = 32'h1004;
    settle();
    chk("ord_i1_addr", mem_bus.addr, 32'h1004);
    tick();
    inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b0;
    mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'hAAAA0000;
    settle();
    chk("ord_r0_inst", 32'(inst_bus.data_ok), 32'd1);
    chk("ord_r0_rdata", inst_bus.rdata, 32'hAAAA0000);
    tick();
    mem_bus.rdata = 32'h0;
    settle();
    chk("ord_r1_data", 32'(data_bus.data_ok), 32'd1);
    chk("ord_r1_inst", 32'(inst_bus.data_ok), 32'd0);
    tick();
    mem_bus.rdata = 32'hBBBB0000;
    settle();
    chk("ord_r2_inst", 32'(inst_bus.data_ok), 32'd1);
    chk("ord_r2_rdata", inst_bus.rdata, 32'hBBBB0000);
    tick();
    mem_bus.data_ok = 1'b0;

    // Full: four loads fill the FIFO, the fifth waits for a response.
    data_bus.req = 1'b1; data_bus.addr = 32'h7000; mem_bus.addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("fill_aok", 32'(data_bus.addr_ok), 32'd1);
      tick();
    end
    settle();
    chk("full_mem_req", 32'(mem_bus.req), 32'd0);
    chk("full_daok", 32'(data_bus.addr_ok), 32'd0);
    tick();
    mem_bus.data_ok = 1'b1;
    settle();
    chk("full_pop_req", 32'(mem_bus.req), 32'd0);
    chk("full_pop_dok", 32'(data_bus.data_ok), 32'd1);
    tick();
    mem_bus.data_ok = 1'b0;
    settle();
    chk("full_resume", 32'(data_bus.addr_ok), 32'd1);
    tick();
    data_bus.req = 1'b0; mem_bus.addr_ok = 1'b0;
    mem_bus.data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("drain_dok", 32'(data_bus.data_ok), 32'd1);
      tick();
    end
    mem_bus.data_ok = 1'b0;

    // Stray response with nothing outstanding.
    mem_bus.data_ok = 1'b1;
    settle();
    chk("stray_idok", 32'(inst_bus.data_ok), 32'd0);
    chk("stray_ddok", 32'(data_bus.data_ok), 32'd0);
    tick();
    mem_bus.data_ok = 1'b0;
    settle();
    chk("stray_err", 32'(err), 32'd1);
    tick();
    chk("stray_err_hold", 32'(err), 32'd1);
    reset = 1'b1;
    settle();
    chk("stray_err_clr", 32'(err), 32'd0);
    tick();
    reset = 1'b0;

    // Asynchronous reset with two outstanding and a lock held.
    inst_bus.req = 1'b1; inst_bus.addr = 32'h8000; mem_bus.addr_ok = 1'b1;
    tick();
    tick();
    mem_bus.addr_ok = 1'b0;
    tick();
    mem_bus.addr_ok = 1'b1; mem_bus.data_ok = 1'b1;
    settle();
    chk("ar_pre_iaok", 32'(inst_bus.addr_ok), 32'd1);
    chk("ar_pre_idok", 32'(inst_bus.data_ok), 32'd1);
    reset = 1'b1;
    settle();
    chk("ar_mem_req", 32'(mem_bus.req), 32'd0);
    chk("ar_iaok", 32'(inst_bus.addr_ok), 32'd0);
    chk("ar_idok", 32'(inst_bus.data_ok), 32'd0);
    chk("ar_mem_addr", mem_bus.addr, 32'd0);
    tick();
    idle();
    reset = 1'b0;
    data_bus.req = 1'b1; data_bus.addr = 32'h6000; mem_bus.addr_ok = 1'b1;
    settle();
    chk("ar_post_daok", 32'(data_bus.addr_ok), 32'd1);
    chk("ar_post_addr", mem_bus.addr, 32'h6000);
    tick();
    data_bus.req = 1'b0; mem_bus.addr_ok = 1'b0;
    settle();
    chk("ar_post_count", 32'(dut.count), 32'd1);
    mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h66;
    settle();
    chk("ar_post_ddok", 32'(data_bus.data_ok), 32'd1);
    chk("ar_post_idok", 32'(inst_bus.data_ok), 32'd0);
    tick();
    mem_bus.data_ok = 1'b0;
    settle();
    chk("ar_post_err", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
